fnd_scan_ctrl: RTL
==================

// Module: fnd_scan_ctrl
// PURPOSE
//  Downstream of the watch top: takes the 14-bit display word {hi[6:0], lo[6:0]} and the 4-bit blink mask.
//  Converts each 7-bit field (0..99) to two BCD digits.
//  Time-multiplexes the digits onto a 4-digit common-anode 7-segment display, with a ghost-suppression blanking gap.
// PARAMETERS
//  CLK_HZ     100_000_000  system clock frequency
//  SCAN_HZ    1_000        per-digit refresh rate; DIV = CLK_HZ/SCAN_HZ cycles per digit slot (must be > BLANK_CYC)
//  BLANK_CYC  16           cycles at the start of each slot with all anodes off
// PORTS
//  iClk        in   1   system clock, rising edge
//  iRstn       in   1   asynchronous, active-low reset
//  iDispData   in   14  [13:7]=hi field (digits 3,2), [6:0]=lo field (digits 1,0), binary
//  iBlinkMask  in   4   bit i=1 -> digit i dark this frame (already phase-gated upstream)
//  oSeg        out  7   {g,f,e,d,c,b,a}, active-low
//  oDp         out  1   decimal point, active-low
//  oAn         out  4   digit anodes, active-low; bit 0 = rightmost digit
// BEHAVIOUR
//  - Reset (async, iRstn=0): oAn=4'b1111, oSeg=7'h7F, oDp=1.
//    Internal state: BLANK, digit index 0, slot counter 0, snapshot = 14'd0, mask snapshot = 4'd0.
//  - FSM per slot: BLANK (BLANK_CYC cycles) -> DRIVE (DIV-BLANK_CYC cycles) -> BLANK of the next digit.
//    Digit index counts 0->1->2->3->0 and wraps at 3.
//  - Snapshot: iDispData and iBlinkMask are registered only on entry to BLANK of digit 0, including the first slot after reset release.
//    A frame therefore never mixes old and new data.
//  - Pipeline: oSeg/oDp are registered during BLANK from snapshot + index, and are stable before the anode turns on.
//  - BLANK: oAn=4'b1111. DRIVE: oAn = ~(4'b0001<<idx), unless mask snapshot bit idx=1, in which case oAn=4'b1111.
//  - First anode assertion: cycle BLANK_CYC after reset release (first cycle counted as 0).
//  - BCD: tens = field/10, ones = field%10, constant-divisor logic, no leading-zero blanking.
//    Field value 100..127 -> both digits of that field show dash 7'b0111111 (segment g only).
//  - Digit codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001,
//    5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
//  - oDp: low (lit) only on digit 2, the hi/lo separator; high (off) on all other digits.
//  - Reset mid-DRIVE: outputs go to reset values in the same cycle, with no clock needed.
//  - Simultaneous input change and snapshot edge: the value present at that edge is captured.
// CONFIGURATION
//  FND_DP_BLINK_EN
//   - Defined: digit-2 DP toggles every 0.5 s, from an internal CLK_HZ/2-cycle counter reset to 0 with DP lit.
//     The toggle is sampled with the frame snapshot.
//   - Undefined: digit-2 DP is lit constantly and no counter is synthesized.
// STRUCTURE
//  - Package fnd_pkg: SEG_DIGIT[0:9] LUT, SEG_DASH=7'b0111111, SEG_OFF=7'h7F, state encodings ST_BLANK/ST_DRIVE.
//  - Sub-module fnd_bin2seg: 7-bit field -> {tens_seg, ones_seg}, combinational, including the >99 dash rule.
//    Two instances, one per field.
//  - Top level holds the FSM, slot counter, digit index, snapshot registers and output registers.
// TESTING (bench params CLK_HZ=1000, SCAN_HZ=100 -> DIV=10, BLANK_CYC=2)
//  1. Hold iRstn=0, then release.
//     -> oAn=1111, oSeg=7F while in reset; first oAn=1110 at cycle 2 after release, held for 8 cycles, then 1111 for 2 cycles.
//  2. iDispData={7'd12,7'd34}, mask 0.
//     -> Digit 0 (oAn=1110) shows 0011001 ('4'); digit 1 shows 0110000 ('3'); digit 2 shows 0100100 ('2') with oDp=0; digit 3 shows 1111001 ('1').
//  3. iBlinkMask=4'b1100.
//     -> During the digit 3 and digit 2 slots oAn stays 1111 for the full slot; digits 1 and 0 drive normally.
//  4. hi=7'd120, lo=7'd5.
//     -> Digits 3 and 2 show 0111111; digit 1 shows 1000000; digit 0 shows 0010010.
//  5. Change iDispData from {12,34} to {56,78} during the digit 1 DRIVE.
//     -> Digits 2 and 3 still show '2' and '1'; the next frame shows 8,7,6,5 on digits 0..3.
//  6. Pull iRstn low at cycle 5 of a DRIVE.
//     -> oAn=1111 and oSeg=7F immediately, before the next clock edge; after release, the scan restarts at digit 0.
//     -> With FND_DP_BLINK_EN, oDp on digit 2 alternates lit/unlit every 500 bench cycles.

Source files
------------

// File: rtl/fnd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : fnd_pkg                                                   |
// | Brief    : Shared 7-segment codes and scan FSM state encoding for    |
// |            the fnd_scan_ctrl display driver.                         |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package fnd_pkg;

  // Scan FSM states: anodes dark (BLANK) or one digit driven (DRIVE).
  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } fndState_t;

  // Segment patterns are {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

  // BCD digit to segment pattern; out-of-range codes blank the digit.
  function automatic logic [6:0] segOfDigit(input logic [3:0] digit);
    logic [6:0] seg;
    seg = SEG_OFF;
    if (digit <= 4'd9) begin
      seg = SEG_DIGIT[digit];
    end
    return seg;
  endfunction

endpackage : fnd_pkg
`default_nettype wire

// File: rtl/fnd_bin2seg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fnd_bin2seg                                               |
// | Brief    : 7-bit binary field (0..99) to two 7-segment patterns      |
// |            (tens, ones). Values 100..127 show a dash on both digits. |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module fnd_bin2seg
  import fnd_pkg::*;
(
  input  logic [6:0] iField,
  output logic [6:0] oTensSeg,
  output logic [6:0] oOnesSeg
);

  logic [3:0] w_tens;
  logic [3:0] w_ones;
  logic [3:0] w_tensX10Lo;
  logic       w_overRange;

  // Divide by 10 as multiply by 205/2048; exact for every 7-bit input.
  assign w_tens = 4'((15'(iField) * 15'd205) >> 11);

  // Remainder fits in 4 bits, so only the low nibble of tens*10 matters.
  assign w_tensX10Lo = {w_tens[0], 3'b000} + {w_tens[2:0], 1'b0};
  assign w_ones      = iField[3:0] - w_tensX10Lo;

  assign w_overRange = (iField > 7'd99);

  // Select digit patterns, forcing dashes when the field exceeds two digits.
  always_comb begin
    oTensSeg = segOfDigit(w_tens);
    oOnesSeg = segOfDigit(w_ones);
    if (w_overRange) begin
      oTensSeg = SEG_DASH;
      oOnesSeg = SEG_DASH;
    end
  end

endmodule : fnd_bin2seg
`default_nettype wire

// File: rtl/fnd_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fnd_scan_ctrl                                             |
// | Brief    : 4-digit common-anode 7-segment scan controller. Converts  |
// |            {hi,lo} binary fields to BCD, snapshots one frame at a    |
// |            time and multiplexes digits with a blanking gap per slot. |
// | Options  : FND_DP_BLINK_EN - digit-2 decimal point toggles every     |
// |            0.5 s instead of being lit constantly.                    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int SCAN_HZ   = 1_000,
  parameter int BLANK_CYC = 16
) (
  input  logic        iClk,
  input  logic        iRstn,
  input  logic [13:0] iDispData,
  input  logic [3:0]  iBlinkMask,
  output logic [6:0]  oSeg,
  output logic        oDp,
  output logic [3:0]  oAn
);

  localparam int                 c_DIV        = CLK_HZ / SCAN_HZ;
  localparam int                 c_CNT_W      = $clog2(c_DIV);
  localparam logic [c_CNT_W-1:0] c_SLOT_LAST  = c_CNT_W'(c_DIV - 1);
  localparam logic [c_CNT_W-1:0] c_BLANK_LAST = c_CNT_W'(BLANK_CYC - 1);

  fndState_t          r_state;
  fndState_t          w_stateNext;
  logic [c_CNT_W-1:0] r_slotCnt;
  logic [c_CNT_W-1:0] w_slotCntNext;
  logic [1:0]         r_digitIdx;
  logic [1:0]         w_digitIdxNext;
  logic [3:0]         r_an;
  logic [3:0]         w_anNext;

  logic               r_firstSlot;
  logic [13:0]        r_dataSnap;
  logic [3:0]         r_maskSnap;
  logic               w_slotEnd;
  logic               w_capture;
  logic [13:0]        w_dataNext;
  logic [3:0]         w_maskNext;
  logic               w_dpLit;

  logic [6:0]         w_hiTensSeg;
  logic [6:0]         w_hiOnesSeg;
  logic [6:0]         w_loTensSeg;
  logic [6:0]         w_loOnesSeg;
  logic [6:0]         w_segSel;
  logic [6:0]         r_seg;
  logic               r_dp;

  // A new frame is captured on the first edge after reset and on every
  // edge that enters the digit-0 slot, so a frame never mixes data.
  assign w_slotEnd  = (r_state == ST_DRIVE) && (r_slotCnt == c_SLOT_LAST);
  assign w_capture  = r_firstSlot || (w_slotEnd && (r_digitIdx == 2'd3));
  assign w_dataNext = w_capture ? iDispData  : r_dataSnap;
  assign w_maskNext = w_capture ? iBlinkMask : r_maskSnap;

`ifdef FND_DP_BLINK_EN
  localparam int                c_HALF_SEC = CLK_HZ / 2;
  localparam int                c_DP_W     = $clog2(c_HALF_SEC);
  localparam logic [c_DP_W-1:0] c_DP_LAST  = c_DP_W'(c_HALF_SEC - 1);

  logic [c_DP_W-1:0] r_dpCnt;
  logic              r_dpPhase;
  logic              r_dpLitSnap;

  // Free-running half-second timer; phase 0 means the separator is lit.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      r_dpCnt   <= '0;
      r_dpPhase <= 1'b0;
    end else if (r_dpCnt == c_DP_LAST) begin
      r_dpCnt   <= '0;
      r_dpPhase <= ~r_dpPhase;
    end else begin
      r_dpCnt   <= r_dpCnt + 1'b1;
    end
  end

  // Blink phase is frozen per frame alongside the display data.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      r_dpLitSnap <= 1'b1;
    end else if (w_capture) begin
      r_dpLitSnap <= ~r_dpPhase;
    end
  end

  assign w_dpLit = w_capture ? ~r_dpPhase : r_dpLitSnap;
`else
  assign w_dpLit = 1'b1;
`endif

  // Frame snapshot registers for display data and blink mask.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      r_firstSlot <= 1'b1;
      r_dataSnap  <= 14'd0;
      r_maskSnap  <= 4'd0;
    end else begin
      r_firstSlot <= 1'b0;
      if (w_capture) begin
        r_dataSnap <= iDispData;
        r_maskSnap <= iBlinkMask;
      end
    end
  end

  fnd_bin2seg u_hiConv (
    .iField   (w_dataNext[13:7]),
    .oTensSeg (w_hiTensSeg),
    .oOnesSeg (w_hiOnesSeg)
  );

  fnd_bin2seg u_loConv (
    .iField   (w_dataNext[6:0]),
    .oTensSeg (w_loTensSeg),
    .oOnesSeg (w_loOnesSeg)
  );

  // Pick the pattern for the digit currently being scanned.
  always_comb begin
    w_segSel = SEG_OFF;
    case (r_digitIdx)
      2'd0:    w_segSel = w_loOnesSeg;
      2'd1:    w_segSel = w_loTensSeg;
      2'd2:    w_segSel = w_hiOnesSeg;
      2'd3:    w_segSel = w_hiTensSeg;
      default: w_segSel = SEG_OFF;
    endcase
  end

  // FSM state, slot counter, digit index and anode register.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      r_state    <= ST_BLANK;
      r_slotCnt  <= '0;
      r_digitIdx <= 2'd0;
      r_an       <= 4'b1111;
    end else begin
      r_state    <= w_stateNext;
      r_slotCnt  <= w_slotCntNext;
      r_digitIdx <= w_digitIdxNext;
      r_an       <= w_anNext;
    end
  end

  // Next-state and anode decode: dark during BLANK, one anode in DRIVE
  // unless the frame's blink mask hides that digit.
  always_comb begin
    w_stateNext    = r_state;
    w_slotCntNext  = r_slotCnt + 1'b1;
    w_digitIdxNext = r_digitIdx;
    w_anNext       = 4'b1111;
    case (r_state)
      ST_BLANK: begin
        if (r_slotCnt == c_BLANK_LAST) begin
          w_stateNext = ST_DRIVE;
          if (!w_maskNext[r_digitIdx]) begin
            w_anNext = ~(4'b0001 << r_digitIdx);
          end
        end
      end
      ST_DRIVE: begin
        if (r_slotCnt == c_SLOT_LAST) begin
          w_stateNext    = ST_BLANK;
          w_slotCntNext  = '0;
          w_digitIdxNext = r_digitIdx + 2'd1;
        end else begin
          w_anNext = r_an;
        end
      end
      default: begin
        w_stateNext   = ST_BLANK;
        w_slotCntNext = '0;
      end
    endcase
  end

  // Segment/DP outputs only change while the anodes are dark, so the
  // pattern is settled before the digit lights.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      r_seg <= SEG_OFF;
      r_dp  <= 1'b1;
    end else if (r_state == ST_BLANK) begin
      r_seg <= w_segSel;
      r_dp  <= (r_digitIdx == 2'd2) ? ~w_dpLit : 1'b1;
    end
  end

  assign oSeg = r_seg;
  assign oDp  = r_dp;
  assign oAn  = r_an;

endmodule : fnd_scan_ctrl
`default_nettype wire
